mux_rr_sched: RTL and testbench



---
 rtl/mux_rr_sched.sv | 162 ++++++++++++++++
 tb/tb_mux_rr_sched.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin owner selection for a shared N_REQ:1 bit mux.
// The holder keeps the mux for at most MAX_HOLD consecutive cycles while
// others wait. Handover between holders happens at a single edge, with no idle
// cycle. All outputs are registered.
module mux_rr_sched #(
    parameter int N_REQ    = 10,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [SEL_W-1:0] sel
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q,  state_d;
    logic [SEL_W-1:0]   ptr_q,    ptr_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [SEL_W-1:0]   holder_q, holder_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic [SEL_W-1:0]   sel_q,    sel_d;
    logic               gnt_valid_q, gnt_valid_d;

    logic [SEL_W:0]     arb;
    logic               arb_found;
    logic [SEL_W-1:0]   arb_win;
    logic [N_REQ-1:0]   holder_mask;
    logic               others_req;

    // First set request scanning start, start+1, ... with wrap. MSB = found.
    function automatic logic [SEL_W:0] arbitrate(input logic [N_REQ-1:0] r,
                                                  input logic [SEL_W-1:0] start);
        logic             found;
        logic [SEL_W-1:0] win;
        int               idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(start) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = SEL_W'(idx);
            end
        end
        return {found, win};
    endfunction

    // Pointer position just after a winner, wrapping past the last requester.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] w);
        return (w == SEL_LAST) ? '0 : w + SEL_W'(1);
    endfunction

    // One-hot decode of a holder index; indices >= N_REQ decode to zero.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] h);
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (SEL_W'(i) == h);
        end
        return v;
    endfunction

    assign arb       = arbitrate(req, ptr_q);
    assign arb_found = arb[SEL_W];
    assign arb_win   = arb[SEL_W-1:0];

    // Requests from anyone other than the current holder.
    always_comb begin
        holder_mask = onehot(holder_q);
        others_req  = |(req & ~holder_mask);
    end

    // Next-state logic: arbitration, hold limit and registered output encode.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        holder_d = holder_q;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d  = GRANT;
                    holder_d = arb_win;
                    ptr_d    = next_ptr(arb_win);
                    cnt_d    = CNT_ONE;
                end
            end
            GRANT: begin
                if (!req[holder_q]) begin
                    // Holder released: hand over immediately or fall idle.
                    if (arb_found) begin
                        holder_d = arb_win;
                        ptr_d    = next_ptr(arb_win);
                        cnt_d    = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_MAX && others_req) begin
                    // Hold limit reached with others waiting. ptr sits just past
                    // the holder, so the holder is scanned last and loses.
                    holder_d = arb_win;
                    ptr_d    = next_ptr(arb_win);
                    cnt_d    = CNT_ONE;
                end else if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_ONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_valid_d = (state_d == GRANT);
        gnt_d       = gnt_valid_d ? onehot(holder_d) : '0;
        sel_d       = gnt_valid_d ? holder_d : '0;
    end

    // State and output registers; reset overrides everything, including req.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            holder_q    <= '0;
            gnt_q       <= '0;
            sel_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            holder_q    <= holder_d;
            gnt_q       <= gnt_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Testbench for mux_rr_sched: directed scenarios followed by random traffic.
// A behavioural model predicts each edge's outputs into a queue. A monitor
// then compares them against the DUT.
module tb_mux_rr_sched;

    localparam int N    = 10;
    localparam int SW   = 4;
    localparam int HOLD = 4;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [SW-1:0] sel;
        logic          vld;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [SW-1:0] sel;

    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    string phase    = "init";

    // Reference model state, kept as plain integers.
    bit m_busy   = 0;
    int m_holder = 0;
    int m_ptr    = 0;
    int m_cnt    = 0;

    mux_rr_sched #(.N_REQ(N), .SEL_W(SW), .MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [N-1:0] q, input int start);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (q[k]) return k;
        end
        return -1;
    endfunction

    // Advance the model by one clock edge and queue the outputs it implies.
    task automatic model_edge(input logic r, input logic [N-1:0] q);
        int   w;
        exp_t e;
        logic [N-1:0] others;
        if (r) begin
            m_busy = 0; m_ptr = 0; m_cnt = 0; m_holder = 0;
        end else if (!m_busy) begin
            w = pick(q, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_holder = w; m_ptr = (w + 1) % N; m_cnt = 1;
            end
        end else begin
            others = q;
            others[m_holder] = 1'b0;
            if (!q[m_holder]) begin
                w = pick(q, m_ptr);
                if (w >= 0) begin
                    m_holder = w; m_ptr = (w + 1) % N; m_cnt = 1;
                end else begin
                    m_busy = 0;
                end
            end else if (m_cnt == HOLD && others != 0) begin
                w = pick(q, m_ptr);
                m_holder = w; m_ptr = (w + 1) % N; m_cnt = 1;
            end else if (m_cnt == HOLD) begin
                m_cnt = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        e.gnt = '0;
        if (m_busy) e.gnt[m_holder] = 1'b1;
        e.sel = m_busy ? SW'(m_holder) : '0;
        e.vld = m_busy;
        exp_q.push_back(e);
    endtask

    // Apply one cycle of stimulus at the falling edge.
    task automatic drive(input logic r, input logic [N-1:0] q, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = r;
            req = q;
            model_edge(r, q);
        end
    endtask

    // Monitor: one expectation per edge, sampled just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc = cyc + 1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (gnt !== e.gnt || sel !== e.sel || gnt_valid !== e.vld) begin
                failures = failures + 1;
                $display("FAIL %s cyc=%0d gnt got %h want %h sel got %0d want %0d valid got %b want %b",
                         phase, cyc, gnt, e.gnt, sel, e.sel, gnt_valid, e.vld);
            end
            checks = checks + 1;
            if (gnt_valid !== (|gnt) || sel >= SW'(N)) begin
                failures = failures + 1;
                $display("FAIL %s_invariant cyc=%0d gnt=%h valid=%b sel=%0d",
                         phase, cyc, gnt, gnt_valid, sel);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] r;
        rst = 1'b1;
        req = '0;

        phase = "reset_pending";
        drive(1'b1, 10'h3FF, 2);
        phase = "full_contention";
        drive(1'b0, 10'h3FF, 45);

        phase = "single_req";
        drive(1'b1, 10'h000, 1);
        drive(1'b0, 10'h080, 10);
        drive(1'b0, 10'h000, 2);

        phase = "early_release";
        drive(1'b1, 10'h000, 1);
        drive(1'b0, 10'h024, 2);
        drive(1'b0, 10'h020, 3);
        drive(1'b0, 10'h000, 1);

        phase = "reset_mid";
        drive(1'b1, 10'h000, 1);
        drive(1'b0, 10'h040, 2);
        drive(1'b1, 10'h040, 1);
        drive(1'b0, 10'h040, 3);
        drive(1'b0, 10'h081, 2);
        drive(1'b0, 10'h000, 1);

        phase = "ptr_wrap";
        drive(1'b1, 10'h000, 1);
        drive(1'b0, 10'h200, 2);
        drive(1'b0, 10'h000, 1);
        drive(1'b0, 10'h009, 3);
        drive(1'b0, 10'h008, 2);
        drive(1'b0, 10'h000, 1);

        phase = "random";
        r = '0;
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] flip;
            flip = N'($urandom) & N'($urandom);
            r = r ^ flip;
            if ($urandom_range(0, 99) == 0) r = 10'h3FF;
            if ($urandom_range(0, 99) == 1) r = '0;
            drive(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, r, 1);
        end
        drive(1'b0, 10'h000, 1);

        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
